// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: initiator side of the general register file bus.
// It accepts one operation, reads up to two source registers over the
// shared port, hands the operands to the ALU with valid/ready, waits for
// the result and writes it back to the destination register.
// The register file samples the bus on the negedge after each posedge, so
// every register access takes exactly one cycle.
// Optional build macro: FORWARD_EN. When it is defined, the controller
// remembers the last value it wrote back. A later read of that same
// register then takes the remembered value in zero cycles and issues no
// register read. When the macro is not defined, every source is read from
// the register file.

`ifndef OPERAND_SIZE_DFLT
`define OPERAND_SIZE_DFLT 8
`endif
`ifndef NUM_REGS_DFLT
`define NUM_REGS_DFLT 8
`endif

module regfile_access_ctrl #(
    parameter int OPERAND_SIZE = `OPERAND_SIZE_DFLT,
    parameter int NUM_REGS     = `NUM_REGS_DFLT
) (
    input  logic                    clk,
    input  logic                    reset,
    // request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NUM_REGS-1:0]     req_src_a,
    input  logic [NUM_REGS-1:0]     req_src_b,
    input  logic                    req_two_src,
    input  logic [NUM_REGS-1:0]     req_dst,
    input  logic                    req_wb,
    // ALU side
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [OPERAND_SIZE-1:0] op_a,
    output logic [OPERAND_SIZE-1:0] op_b,
    input  logic                    res_valid,
    input  logic [OPERAND_SIZE-1:0] res_data,
    // register file bus
    output logic                    rf_enable,
    output logic                    rf_read,
    output logic                    rf_write,
    output logic [NUM_REGS-1:0]     rf_select,
    output logic [OPERAND_SIZE-1:0] rf_wdata,
    input  logic [OPERAND_SIZE-1:0] rf_rdata,
    // status
    output logic                    done,
    output logic                    err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_A     = 3'd1;
    localparam logic [2:0] S_RD_B     = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_WAIT_RES = 3'd4;
    localparam logic [2:0] S_WR       = 3'd5;

    // The select bus is NUM_REGS bits wide, so it can hold NUM_REGS itself.
    // Any index at or above that value is illegal.
    localparam logic [NUM_REGS-1:0] REG_LIMIT = NUM_REGS[NUM_REGS-1:0];

    logic [2:0]              state_q,     state_d;
    logic [NUM_REGS-1:0]     src_a_q,     src_a_d;
    logic [NUM_REGS-1:0]     src_b_q,     src_b_d;
    logic [NUM_REGS-1:0]     dst_q,       dst_d;
    logic                    two_src_q,   two_src_d;
    logic                    wb_q,        wb_d;
    logic [OPERAND_SIZE-1:0] op_a_q,      op_a_d;
    logic [OPERAND_SIZE-1:0] op_b_q,      op_b_d;
    logic                    op_valid_q,  op_valid_d;
    logic                    rf_enable_q, rf_enable_d;
    logic                    rf_read_q,   rf_read_d;
    logic                    rf_write_q,  rf_write_d;
    logic [NUM_REGS-1:0]     rf_select_q, rf_select_d;
    logic [OPERAND_SIZE-1:0] rf_wdata_q,  rf_wdata_d;
    logic                    done_q,      done_d;
    logic                    err_q,       err_d;
    logic                    idx_bad;

`ifdef FORWARD_EN
    logic [NUM_REGS-1:0]     last_dst_q,  last_dst_d;
    logic [OPERAND_SIZE-1:0] last_val_q,  last_val_d;
    logic                    last_vld_q,  last_vld_d;
`endif

    // Request legality: only the indices that the operation will use are checked.
    always_comb begin
        idx_bad = (req_src_a >= REG_LIMIT)
                | (req_two_src & (req_src_b >= REG_LIMIT))
                | (req_wb      & (req_dst   >= REG_LIMIT));
    end

    // Sequencing. The bus and handshake outputs are registered. They are
    // decoded from the next state, so each one is valid during the cycle
    // in which its state is occupied.
    always_comb begin
        state_d    = state_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        dst_d      = dst_q;
        two_src_d  = two_src_q;
        wb_d       = wb_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef FORWARD_EN
        last_dst_d = last_dst_q;
        last_val_d = last_val_q;
        last_vld_d = last_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    src_a_d   = req_src_a;
                    src_b_d   = req_src_b;
                    dst_d     = req_dst;
                    two_src_d = req_two_src;
                    wb_d      = req_wb;
                    if (idx_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RD_A;
                        // With a single source, op_b is presented as zero.
                        if (!req_two_src) op_b_d = '0;
                    end
                end
            end
            S_RD_A: begin
                op_a_d  = rf_rdata;
                state_d = two_src_q ? S_RD_B : S_ISSUE;
            end
            S_RD_B: begin
                op_b_d  = rf_rdata;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    rf_wdata_d = res_data;
                    if (wb_q) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef FORWARD_EN
                last_dst_d = dst_q;
                last_val_d = rf_wdata_q;
                last_vld_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FORWARD_EN
        // A forwarding hit skips the read state entirely. RD_A is checked
        // first and RD_B second, so two hits in a row go straight to ISSUE.
        if (state_d == S_RD_A && last_vld_q && src_a_d == last_dst_q) begin
            op_a_d  = last_val_q;
            state_d = two_src_d ? S_RD_B : S_ISSUE;
        end
        if (state_d == S_RD_B && state_q != S_RD_B && last_vld_q &&
            src_b_d == last_dst_q) begin
            op_b_d  = last_val_q;
            state_d = S_ISSUE;
        end
`endif

        rf_enable_d = (state_d == S_RD_A) | (state_d == S_RD_B) | (state_d == S_WR);
        rf_read_d   = (state_d == S_RD_A) | (state_d == S_RD_B);
        rf_write_d  = (state_d == S_WR);
        op_valid_d  = (state_d == S_ISSUE);
        case (state_d)
            S_RD_A:  rf_select_d = src_a_d;
            S_RD_B:  rf_select_d = src_b_d;
            S_WR:    rf_select_d = dst_d;
            default: rf_select_d = rf_select_q;
        endcase
    end

    // State and output registers. A synchronous reset abandons any
    // operation that is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            two_src_q   <= 1'b0;
            wb_q        <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_valid_q  <= 1'b0;
            rf_enable_q <= 1'b0;
            rf_read_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_select_q <= '0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            two_src_q   <= two_src_d;
            wb_q        <= wb_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_valid_q  <= op_valid_d;
            rf_enable_q <= rf_enable_d;
            rf_read_q   <= rf_read_d;
            rf_write_q  <= rf_write_d;
            rf_select_q <= rf_select_d;
            rf_wdata_q  <= rf_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef FORWARD_EN
    // Forwarding memory of the most recent write-back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_dst_q <= '0;
            last_val_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_dst_q <= last_dst_d;
            last_val_q <= last_val_d;
            last_vld_q <= last_vld_d;
        end
    end
`endif

    assign req_ready = (state_q == S_IDLE);
    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rf_enable = rf_enable_q;
    assign rf_read   = rf_read_q;
    assign rf_write  = rf_write_q;
    assign rf_select = rf_select_q;
    assign rf_wdata  = rf_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl. It contains a negedge register-file
// model and scoreboards for the operands handed to the ALU and for the
// register writes.
module tb_regfile_access_ctrl;

    localparam int W = 8;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_src_a = '0, req_src_b = '0, req_dst = '0;
    logic         req_two_src = 1'b0, req_wb = 1'b0;
    logic         op_valid;
    logic         op_ready = 1'b0;
    logic [W-1:0] op_a, op_b;
    logic         res_valid = 1'b0;
    logic [W-1:0] res_data = '0;
    logic         rf_enable, rf_read, rf_write;
    logic [N-1:0] rf_select;
    logic [W-1:0] rf_wdata;
    logic [W-1:0] rf_rdata = '0;
    logic         done, err;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_reads = 0;
    int saved;

    logic [W-1:0]   mem [0:N-1] = '{8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [2*W-1:0] op_q [$];
    logic [N+W-1:0] wr_q [$];

    regfile_access_ctrl #(.OPERAND_SIZE(W), .NUM_REGS(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_a(req_src_a), .req_src_b(req_src_b), .req_two_src(req_two_src),
        .req_dst(req_dst), .req_wb(req_wb),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_data(res_data),
        .rf_enable(rf_enable), .rf_read(rf_read), .rf_write(rf_write),
        .rf_select(rf_select), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic two,
                        input logic [N-1:0] d, input logic wb);
        req_valid = 1'b1; req_src_a = a; req_src_b = b;
        req_two_src = two; req_dst = d; req_wb = wb;
        tick();
        req_valid = 1'b0;
    endtask

    // Register file model: acts on the negedge following each bus cycle.
    always @(negedge clk) begin
        if (rf_enable === 1'b1 && rf_read === 1'b1) rf_rdata <= mem[rf_select[2:0]];
        if (rf_enable === 1'b1 && rf_write === 1'b1) mem[rf_select[2:0]] <= rf_wdata;
    end

    // Bus monitors and scoreboards.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (rf_enable === 1'b1) chk("rd_wr_exclusive", {31'd0, rf_read & rf_write}, 32'd0);
            if (rf_enable === 1'b1 && rf_read === 1'b1) n_reads++;
            if (rf_enable === 1'b1 && rf_write === 1'b1) begin
                n_writes++;
                chk("write_expected", {31'd0, wr_q.size() > 0}, 32'd1);
                if (wr_q.size() > 0) chk("write_sel_data", {16'd0, rf_select, rf_wdata}, {16'd0, wr_q.pop_front()});
            end
            if (op_valid === 1'b1 && op_ready === 1'b1) begin
                chk("issue_expected", {31'd0, op_q.size() > 0}, 32'd1);
                if (op_q.size() > 0) chk("issue_operands", {16'd0, op_a, op_b}, {16'd0, op_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_rf_enable", rf_enable, 0);
        chk("rst_rf_read", rf_read, 0);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_zero_data", {op_a, op_b, rf_select, rf_wdata}, 0);
        reset = 1'b1;
        tick();

        // Basic two-source operation with write-back, with no stalls
        op_ready = 1'b1;
        op_q.push_back({8'h12, 8'h34});
        wr_q.push_back({8'd3, 8'h46});
        send(8'd1, 8'd2, 1'b1, 8'd3, 1'b1);             // cycle 1: RD_A
        chk("c1_read", {rf_enable, rf_read, rf_write}, 3'b110);
        chk("c1_sel", rf_select, 1);
        chk("c1_busy", req_ready, 0);
        tick();                                          // cycle 2: RD_B
        chk("c2_read", {rf_enable, rf_read, rf_write}, 3'b110);
        chk("c2_sel", rf_select, 2);
        chk("c2_op_a", op_a, 8'h12);
        tick();                                          // cycle 3: ISSUE
        chk("c3_valid", op_valid, 1);
        chk("c3_op_b", op_b, 8'h34);
        chk("c3_bus_idle", rf_enable, 0);
        tick();                                          // cycle 4: WAIT_RES
        chk("c4_valid_drop", op_valid, 0);
        res_valid = 1'b1; res_data = 8'h46;
        tick();                                          // cycle 5: WR
        res_valid = 1'b0;
        chk("c5_write", {rf_enable, rf_read, rf_write}, 3'b101);
        chk("c5_sel_data", {rf_select, rf_wdata}, {8'd3, 8'h46});
        chk("c5_no_done", done, 0);
        tick();                                          // cycle 6
        chk("c6_done_ready", {done, req_ready, rf_enable}, 3'b110);
        tick();
        chk("c7_done_low", done, 0);
        chk("mem3", mem[3], 8'h46);

        // ALU stall: op_ready is held low for 3 cycles, and a stray res_valid arrives in ISSUE
        op_ready = 1'b0;
        op_q.push_back({8'h12, 8'h34});
        wr_q.push_back({8'd3, 8'h77});
        send(8'd1, 8'd2, 1'b1, 8'd3, 1'b1);
        tick();
        tick();                                          // ISSUE #1
        chk("st_valid1", op_valid, 1);
        res_valid = 1'b1; res_data = 8'h99;
        tick();                                          // ISSUE #2
        res_valid = 1'b0;
        chk("st_valid2", {op_valid, op_a, op_b}, {1'b1, 8'h12, 8'h34});
        tick();                                          // ISSUE #3
        chk("st_valid3", {op_valid, op_a, op_b}, {1'b1, 8'h12, 8'h34});
        tick();                                          // ISSUE #4
        chk("st_valid4", {op_valid, op_a, op_b}, {1'b1, 8'h12, 8'h34});
        op_ready = 1'b1;
        tick();                                          // WAIT_RES
        chk("st_valid_drop", op_valid, 0);
        res_valid = 1'b1; res_data = 8'h77;
        tick();                                          // WR
        res_valid = 1'b0;
        chk("st_wdata", {rf_write, rf_wdata}, {1'b1, 8'h77});
        tick();
        chk("st_done", done, 1);

        // Single source and no write-back
        op_q.push_back({8'h34, 8'h00});
        saved = n_writes;
        send(8'd2, 8'd5, 1'b0, 8'd7, 1'b0);
        chk("ss_read_sel", {rf_read, rf_select}, {1'b1, 8'd2});
        tick();                                          // ISSUE
        chk("ss_issue", {op_valid, op_a, op_b}, {1'b1, 8'h34, 8'h00});
        tick();                                          // WAIT_RES
        chk("ss_wait", {op_valid, rf_enable}, 2'b00);
        tick();
        chk("ss_no_early_done", done, 0);
        res_valid = 1'b1; res_data = 8'h11;
        tick();
        res_valid = 1'b0;
        chk("ss_done", {done, rf_write, req_ready}, 3'b101);
        chk("ss_no_write", n_writes, saved);
        tick();

        // Illegal destination index
        send(8'd1, 8'd2, 1'b1, 8'd8, 1'b1);
        chk("err_pulse", {err, rf_enable, req_ready, done}, 4'b1010);
        tick();
        chk("err_clear", {err, rf_enable, req_ready, done}, 4'b0010);

        // Write 0x5A to r4, then read r4 (forwarded when the feature is enabled)
        op_q.push_back({8'h12, 8'h00});
        wr_q.push_back({8'd4, 8'h5A});
        send(8'd1, 8'd0, 1'b0, 8'd4, 1'b1);
        tick();                                          // ISSUE
        tick();                                          // WAIT_RES
        res_valid = 1'b1; res_data = 8'h5A;
        tick();                                          // WR
        res_valid = 1'b0;
        tick();
        chk("fw_setup_done", done, 1);
        tick();
        saved = n_reads;
        op_q.push_back({8'h5A, 8'h00});
        send(8'd4, 8'd0, 1'b0, 8'd0, 1'b0);
`ifdef FORWARD_EN
        chk("fw_issue_now", {op_valid, rf_read, op_a}, {1'b1, 1'b0, 8'h5A});
`else
        chk("fw_read_r4", {rf_read, rf_select}, {1'b1, 8'd4});
        tick();
        chk("fw_issue", {op_valid, op_a}, {1'b1, 8'h5A});
`endif
        tick();                                          // WAIT_RES
        res_valid = 1'b1; res_data = 8'h00;
        tick();
        res_valid = 1'b0;
        chk("fw_done", done, 1);
`ifdef FORWARD_EN
        chk("fw_read_count", n_reads - saved, 0);
`else
        chk("fw_read_count", n_reads - saved, 1);
`endif
        tick();

        // Reset held for 2 cycles in the middle of RD_B
        send(8'd1, 8'd2, 1'b1, 8'd6, 1'b1);
        tick();                                          // RD_B
        chk("mr_in_rd_b", {rf_read, rf_select}, {1'b1, 8'd2});
        reset = 1'b0;
        tick();
        chk("mr_bus_off", {rf_enable, rf_read, rf_write, op_valid}, 4'b0000);
        chk("mr_ready", req_ready, 1);
        tick();
        reset = 1'b1;
        tick(); tick(); tick(); tick();
        chk("mr_idle", {req_ready, rf_enable, done}, 3'b100);
        chk("mr_mem6", mem[6], 8'h00);

        chk("op_q_empty", op_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
